// File: rtl/sram_like_hub_if.sv
// Single-port SRAM-like bus between a master and the hub.
// Ports: req/we/addr/wdata from the master; rdata/rvalid/irq from the hub.
interface sram_like_hub_if #(
    parameter int DW = 16
) ();
    logic          req;
    logic          we;
    logic [7:0]    addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          irq;

    modport master (
        output req, we, addr, wdata,
        input  rdata, rvalid, irq
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, rvalid, irq
    );
endinterface

// File: rtl/sram_like_hub.sv
// Register hub: CTRL/STATUS, operand regs with registered SUM, FWFT FIFO, RAM window.
// Ports: clk, rst (async, active-high), bus (slave side of sram_like_hub_if).
module sram_like_hub #(
    parameter int DW         = 16,
    parameter int N_OPS      = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int RAM_DEPTH  = 128,
    parameter int SAT_SUM    = 0
) (
    input logic          clk,
    input logic          rst,
    sram_like_hub_if.slave bus
);
    localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int RAW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int SW  = DW + 3;
    localparam logic [7:0]    RAM_LIM  = 8'(RAM_DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic          en;
    logic          irq_en;
    logic [DW-1:0] ops [N_OPS];
    logic [DW-1:0] sum_q;
    logic          sum_ovf_q;
    logic [DW-1:0] fifo_mem [FIFO_DEPTH];
    logic [DW-1:0] ram [RAM_DEPTH];
    logic [FAW-1:0] wr_ptr;
    logic [FAW-1:0] rd_ptr;
    logic [CW-1:0]  count;
    logic          ovf;
    logic          udf;
    logic          rvalid_q;
    logic [DW-1:0] rdata_q;

    logic          rd;
    logic          wr;
    logic          sel_ctrl;
    logic          sel_stat;
    logic          sel_sum;
    logic          sel_fifo;
    logic          sel_ram;
    logic [RAW-1:0] ram_idx;
    logic          op_hit;
    logic [DW-1:0] op_rd;
    logic [N_OPS-1:0] op_we;
    logic [SW-1:0] sum_full;
    logic          sum_big;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [DW-1:0] stat;
    logic [DW-1:0] rd_val;

    assign rd       = bus.req & ~bus.we;
    assign wr       = bus.req & bus.we;
    assign sel_ctrl = (bus.addr == 8'h00);
    assign sel_stat = (bus.addr == 8'h01);
    assign sel_sum  = (bus.addr == 8'h10);
    assign sel_fifo = (bus.addr == 8'h11);
    assign sel_ram  = bus.addr[7] & ({1'b0, bus.addr[6:0]} < RAM_LIM);
    assign ram_idx  = bus.addr[RAW-1:0];

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    // Raw intent; overflow/underflow is resolved against full/empty below.
    assign push  = wr & sel_fifo & en;
    assign pop   = rd & sel_fifo & en;

    always_comb begin
        op_hit = 1'b0;
        op_rd  = '0;
        op_we  = '0;
        for (int i = 0; i < N_OPS; i++) begin
            if (bus.addr == 8'(i + 2)) begin
                op_hit   = 1'b1;
                op_rd    = ops[i];
                op_we[i] = wr & en;
            end
        end
    end

    // Three guard bits hold the sum of up to eight operands without loss.
    always_comb begin
        sum_full = '0;
        for (int i = 0; i < N_OPS; i++) begin
            sum_full = sum_full + SW'(ops[i]);
        end
    end
    assign sum_big = |sum_full[SW-1:DW];

    // Count lands in [15:8]; on narrow buses it simply shifts out.
    assign stat = (DW'(count) << 8)
                | DW'({sum_ovf_q, udf, ovf, full, empty});

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            sel_ctrl: rd_val[1:0] = {irq_en, en};
            sel_stat: rd_val = stat;
            sel_sum:  if (en) rd_val = sum_q;
            sel_fifo: if (en && !empty) rd_val = fifo_mem[rd_ptr];
            sel_ram:  if (en) rd_val = ram[ram_idx];
            op_hit:   if (en) rd_val = op_rd;
            default:  rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en        <= 1'b0;
            irq_en    <= 1'b0;
            sum_q     <= '0;
            sum_ovf_q <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            for (int i = 0; i < N_OPS; i++) begin
                ops[i] <= '0;
            end
        end else begin
            rvalid_q <= rd;
            rdata_q  <= rd ? rd_val : '0;

            if (wr && sel_ctrl) begin
                en     <= bus.wdata[0];
                irq_en <= bus.wdata[1];
            end

            for (int i = 0; i < N_OPS; i++) begin
                if (op_we[i]) ops[i] <= bus.wdata;
            end

            sum_ovf_q <= sum_big;
            if (sum_big && SAT_SUM != 0) sum_q <= '1;
            else                         sum_q <= sum_full[DW-1:0];

            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count - 1'b1;
            end

            // A setting event takes priority over a W1C clear.
            if (push && full)
                ovf <= 1'b1;
            else if (wr && sel_stat && bus.wdata[2])
                ovf <= 1'b0;

            if (pop && empty)
                udf <= 1'b1;
            else if (wr && sel_stat && bus.wdata[3])
                udf <= 1'b0;
        end
    end

    // Storage arrays carry no reset.
    always_ff @(posedge clk) begin
        if (push && !full) fifo_mem[wr_ptr] <= bus.wdata;
        if (wr && sel_ram && en) ram[ram_idx] <= bus.wdata;
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.irq    = (ovf | udf | sum_ovf_q) & irq_en;
endmodule
